delta_hadamard: RTL and testbench
=================================

# delta_hadamard

Backpropagation stage directly downstream of the transposed-weight matrix-vector multiplier. Takes the back-propagated error vector produced by that stage and the layer's stored forward activations, forms the sigmoid derivative a·(1−a) per cell, and outputs the layer delta δ = e ⊙ a·(1−a) in fixed point. Processes TILING cells per cycle and exposes the same start/valid/error contract as its upstream neighbour, so its `start` can be driven from that block's `valid`.

## Interface
- VECTOR_LEN, 5, number of cells in error, activation and result vectors
- ERROR_CELL_WIDTH, 8, signed two's-complement width of each error cell
- ACTIVATION_CELL_WIDTH, 8, unsigned width of each activation cell
- RESULT_CELL_WIDTH, 8, signed width of each delta cell
- FRACTION, 4, fraction bits shared by all three formats; ONE = 1<<FRACTION
- TILING, 2, cells processed per cycle (1..VECTOR_LEN)

- clk  input  1  clock; all state on rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  sampled in IDLE only; launches one operation
- error_vector  input  VECTOR_LEN*ERROR_CELL_WIDTH  upstream error, cell i at [i*W +: W]
- activation  input  VECTOR_LEN*ACTIVATION_CELL_WIDTH  forward activations, same packing
- result  output  VECTOR_LEN*RESULT_CELL_WIDTH  delta vector, same packing
- valid  output  1  level; high from completion until next accepted start
- error  output  1  overflow in any cell of the completed operation

## Operation
- States: IDLE, RUN. Reset (rst low) asynchronously forces IDLE, idx=0, result=0, valid=0, error=0, internal sticky flag=0, latched vectors=0.
- IDLE, start=1: latch error_vector and activation, result←0, valid←0, error←0, sticky←0, idx←0, go RUN. start=0: hold everything.
- RUN, each cycle: for lanes j in 0..TILING−1 with idx+j < VECTOR_LEN compute cell idx+j; lanes past VECTOR_LEN (partial last tile) do nothing. idx←idx+TILING.
- Last tile (idx+TILING ≥ VECTOR_LEN): go IDLE, valid←1, error←sticky OR this tile's overflow.
- start during RUN ignored; inputs not re-sampled. Inputs may change freely after the start edge.
- Per cell: a' = min(a, ONE) (activations above ONE give derivative 0). d = (a'·(ONE−a')) >> FRACTION, unsigned, ≤ ONE/4. p = e·d signed at ERROR_CELL_WIDTH+ACTIVATION_CELL_WIDTH+1 bits, then arithmetic >>> FRACTION (rounds toward −∞).
- Overflow: p outside [−2^(R−1), 2^(R−1)−1], R=RESULT_CELL_WIDTH; sets sticky. Cell write per Configuration.

## Timing
- start sampled at edge S → RUN cycles at edges S+1..S+K, K = ceil(VECTOR_LEN/TILING); valid and error rise at edge S+K.
- Earliest next start sampled at edge S+K+1 (back-to-back: valid high exactly one cycle, drops at that edge).
- result cells update progressively during RUN; only meaningful while valid=1.
- error changes only at the valid-rise edge and at accepted start.

## Configuration
- DELTA_SATURATE_EN defined: overflowing cells clamp to 2^(R−1)−1 or −2^(R−1); error still asserted.
- Not defined: overflowing cells take the low R bits of p (wrap); error still asserted. Non-overflowing cells identical in both builds.

## Structure
- Shared package nn_pkg: fixed-point ONE/FRACTION helpers, saturate/truncate function, state encoding constants IDLE/RUN reused by neighbouring stages.
- One sub-module, sigmoid_derivative_lane: combinational a' clamp, derivative, product, shift, overflow flag for one cell; instantiated TILING times, fed by idx-indexed slices. FSM, idx counter, buffers in top.

## Test plan
- FRACTION=4, all a=8 (0.5), all e=16 (1.0) → d=4, every result cell 4, valid at S+3 (N=5,T=2), error=0.
- Signed: e=−32, a=4 → d=(4·12)>>4=3, p=−96>>>4=−6 → cell −6; a=0 or a=16 or a=200 → cell 0.
- ERROR_CELL_WIDTH=12, e=2047, a=8 → p=511: with DELTA_SATURATE_EN cell 127, without cell −1 (0x1FF low 8 bits); error=1 both builds, other cells unaffected.
- start pulsed every cycle for 10 cycles → exactly one operation per K+1 cycles; start during RUN ignored; inputs changed mid-RUN don't alter result.
- rst low at edge S+2 mid-RUN → result, valid, error 0 immediately; next start runs cleanly with correct results.
- TILING=1 and TILING=VECTOR_LEN → K=5 and K=1 respectively, identical result vectors.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared fixed-point helpers and FSM state encoding for the backpropagation stages.
package nn_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int fxOne(input int frac);
    return 1 <<< frac;
  endfunction

  function automatic int cellMax(input int rw);
    return (1 <<< (rw - 1)) - 1;
  endfunction

  function automatic int cellMin(input int rw);
    return -(1 <<< (rw - 1));
  endfunction

  function automatic logic cellOverflows(input int p, input int rw);
    return (p > cellMax(rw)) || (p < cellMin(rw));
  endfunction

  // Clamp to the signed range of an rw-bit cell; callers wanting wrap slice the low bits instead.
  function automatic int saturateCell(input int p, input int rw);
    if (p > cellMax(rw)) begin
      return cellMax(rw);
    end else if (p < cellMin(rw)) begin
      return cellMin(rw);
    end
    return p;
  endfunction

endpackage

// File: rtl/sigmoid_derivative_lane.sv
// One delta cell: e * a'(1-a') in fixed point with overflow flag.
// DELTA_SATURATE_EN selects clamping of overflowing cells; otherwise they wrap.
module sigmoid_derivative_lane
  import nn_pkg::*;
#(
  parameter int ERROR_CELL_WIDTH      = 8,
  parameter int ACTIVATION_CELL_WIDTH = 8,
  parameter int RESULT_CELL_WIDTH     = 8,
  parameter int FRACTION              = 4
) (
  input  logic [ERROR_CELL_WIDTH-1:0]      i_error,
  input  logic [ACTIVATION_CELL_WIDTH-1:0] i_activation,
  output logic [RESULT_CELL_WIDTH-1:0]     o_cell,
  output logic                             o_overflow
);

  localparam int EW  = ERROR_CELL_WIDTH;
  localparam int AW  = ACTIVATION_CELL_WIDTH;
  localparam int RW  = RESULT_CELL_WIDTH;
  localparam int DW  = FRACTION + 1;
  localparam int PW  = EW + AW + 1;
  localparam int ONE = 1 <<< FRACTION;

  logic [DW-1:0]          w_aClamp;
  logic [DW-1:0]          w_oneMinusA;
  logic [2*DW-1:0]        w_derivFull;
  logic [DW-1:0]          w_deriv;
  logic signed [PW-1:0]   w_errExt;
  logic signed [PW-1:0]   w_derivExt;
  logic signed [PW-1:0]   w_prod;
  logic signed [PW-1:0]   w_shifted;
  int                     w_shiftedInt;

  // Activations above ONE sit on the flat part of the curve, so their derivative is zero.
  always_comb begin
    w_aClamp     = (i_activation > AW'(ONE)) ? DW'(ONE) : i_activation[DW-1:0];
    w_oneMinusA  = DW'(ONE) - w_aClamp;
    w_derivFull  = {{DW{1'b0}}, w_aClamp} * {{DW{1'b0}}, w_oneMinusA};
    w_deriv      = w_derivFull[FRACTION +: DW];
    w_errExt     = {{(PW-EW){i_error[EW-1]}}, i_error};
    w_derivExt   = {{(PW-DW){1'b0}}, w_deriv};
    w_prod       = w_errExt * w_derivExt;
    w_shifted    = w_prod >>> FRACTION;
    w_shiftedInt = int'(w_shifted);
  end

  always_comb begin
    o_overflow = cellOverflows(w_shiftedInt, RW);
`ifdef DELTA_SATURATE_EN
    o_cell = RW'(saturateCell(w_shiftedInt, RW));
`else
    o_cell = w_shifted[RW-1:0];
`endif
  end

endmodule

// File: rtl/delta_hadamard.sv
// Layer delta e .* a(1-a), TILING cells per cycle, start/valid/error handshake.
// Overflow handling of cells is selected by DELTA_SATURATE_EN (clamp) vs. default wrap.
module delta_hadamard
  import nn_pkg::*;
#(
  parameter int VECTOR_LEN            = 5,
  parameter int ERROR_CELL_WIDTH      = 8,
  parameter int ACTIVATION_CELL_WIDTH = 8,
  parameter int RESULT_CELL_WIDTH     = 8,
  parameter int FRACTION              = 4,
  parameter int TILING                = 2
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start,
  input  logic [VECTOR_LEN*ERROR_CELL_WIDTH-1:0]         error_vector,
  input  logic [VECTOR_LEN*ACTIVATION_CELL_WIDTH-1:0]    activation,
  output logic [VECTOR_LEN*RESULT_CELL_WIDTH-1:0]        result,
  output logic                                           valid,
  output logic                                           error
);

  localparam int EW = ERROR_CELL_WIDTH;
  localparam int AW = ACTIVATION_CELL_WIDTH;
  localparam int RW = RESULT_CELL_WIDTH;
  localparam int IW = $clog2(VECTOR_LEN + TILING + 1);

  state_t                     r_state;
  logic [IW-1:0]              r_idx;
  logic [VECTOR_LEN*EW-1:0]   r_errVec;
  logic [VECTOR_LEN*AW-1:0]   r_actVec;
  logic [VECTOR_LEN*RW-1:0]   r_result;
  logic                       r_valid;
  logic                       r_error;
  logic                       r_sticky;

  logic [IW-1:0]              w_laneIdx  [TILING];
  logic                       w_laneLive [TILING];
  logic [RW-1:0]              w_laneCell [TILING];
  logic                       w_laneOvf  [TILING];
  logic                       w_tileOvf;
  logic                       w_lastTile;

  // Lanes past the end of the vector on the final tile are parked on cell 0 and ignored.
  always_comb begin
    for (int j = 0; j < TILING; j++) begin
      w_laneLive[j] = (int'(r_idx) + j) < VECTOR_LEN;
      w_laneIdx[j]  = w_laneLive[j] ? IW'(int'(r_idx) + j) : '0;
    end
    w_lastTile = (int'(r_idx) + TILING) >= VECTOR_LEN;
  end

  always_comb begin
    w_tileOvf = 1'b0;
    for (int j = 0; j < TILING; j++) begin
      if (w_laneLive[j] && w_laneOvf[j]) begin
        w_tileOvf = 1'b1;
      end
    end
  end

  for (genvar j = 0; j < TILING; j++) begin : g_lane
    sigmoid_derivative_lane #(
      .ERROR_CELL_WIDTH      (EW),
      .ACTIVATION_CELL_WIDTH (AW),
      .RESULT_CELL_WIDTH     (RW),
      .FRACTION              (FRACTION)
    ) u_lane (
      .i_error      (r_errVec[w_laneIdx[j]*EW +: EW]),
      .i_activation (r_actVec[w_laneIdx[j]*AW +: AW]),
      .o_cell       (w_laneCell[j]),
      .o_overflow   (w_laneOvf[j])
    );
  end

  // Inputs are captured once at start so the upstream stage may move on immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_errVec <= '0;
      r_actVec <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_error  <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_errVec <= error_vector;
            r_actVec <= activation;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_error  <= 1'b0;
            r_sticky <= 1'b0;
            r_idx    <= '0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          for (int j = 0; j < TILING; j++) begin
            if (w_laneLive[j]) begin
              r_result[w_laneIdx[j]*RW +: RW] <= w_laneCell[j];
            end
          end
          r_idx    <= r_idx + IW'(TILING);
          r_sticky <= r_sticky | w_tileOvf;
          if (w_lastTile) begin
            r_state <= IDLE;
            r_valid <= 1'b1;
            r_error <= r_sticky | w_tileOvf;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign result = r_result;
  assign valid  = r_valid;
  assign error  = r_error;

endmodule

// File: tb/tb_delta_hadamard.sv
// Directed bench for delta_hadamard: default, wide-error, TILING=1 and TILING=VECTOR_LEN instances.
module tb_delta_hadamard;

  logic        clk;
  logic        rst;
  logic        start;
  logic        startW;
  logic [39:0] errVec;
  logic [39:0] actVec;
  logic [59:0] errVecW;
  logic [39:0] actVecW;

  logic [39:0] resMain, resT1, resT5, resW;
  logic        validMain, validT1, validT5, validW;
  logic        errMain, errT1, errT5, errW;

  int checks;
  int failures;
  int latMain, latT1, latT5, latW;
  int rises;
  logic prevValid;
  logic validAtE5;

`ifdef DELTA_SATURATE_EN
  localparam logic [39:0] EXP_W_OVF = 40'h00_ED_12_80_7F;
`else
  localparam logic [39:0] EXP_W_OVF = 40'h00_ED_12_00_FF;
`endif
  localparam logic [39:0] EXP_FOURS  = 40'h04_04_04_04_04;
  localparam logic [39:0] EXP_MIXED  = 40'h00_FE_00_00_FA;
  localparam logic [39:0] E_MIXED    = 40'hE0_FB_E0_E0_E0;
  localparam logic [39:0] A_MIXED    = 40'hC8_08_10_00_04;
  localparam logic [59:0] E_W_OVF    = 60'h000_F9C_064_800_7FF;
  localparam logic [39:0] A_W_OVF    = 40'h08_04_04_08_08;

  delta_hadamard dut (
    .clk(clk), .rst(rst), .start(start), .error_vector(errVec), .activation(actVec),
    .result(resMain), .valid(validMain), .error(errMain)
  );

  delta_hadamard #(.TILING(1)) dutT1 (
    .clk(clk), .rst(rst), .start(start), .error_vector(errVec), .activation(actVec),
    .result(resT1), .valid(validT1), .error(errT1)
  );

  delta_hadamard #(.TILING(5)) dutT5 (
    .clk(clk), .rst(rst), .start(start), .error_vector(errVec), .activation(actVec),
    .result(resT5), .valid(validT5), .error(errT5)
  );

  delta_hadamard #(.ERROR_CELL_WIDTH(12)) dutW (
    .clk(clk), .rst(rst), .start(startW), .error_vector(errVecW), .activation(actVecW),
    .result(resW), .valid(validW), .error(errW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are inverted right after the start edge to prove they are not re-sampled.
  task automatic applyStimulus(input logic [39:0] e, input logic [39:0] a);
    @(negedge clk);
    errVec = e;
    actVec = a;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    errVec = ~e;
    actVec = ~a;
  endtask

  task automatic applyStimulusWide(input logic [59:0] e, input logic [39:0] a);
    @(negedge clk);
    errVecW = e;
    actVecW = a;
    startW  = 1'b1;
    @(posedge clk);
    #1;
    startW  = 1'b0;
    errVecW = ~e;
    actVecW = ~a;
  endtask

  task automatic waitValid();
    latMain = 0; latT1 = 0; latT5 = 0; latW = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (validMain && latMain == 0) latMain = c;
      if (validT1 && latT1 == 0) latT1 = c;
      if (validT5 && latT5 == 0) latT5 = c;
      if (validW && latW == 0) latW = c;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    start    = 1'b0;
    startW   = 1'b0;
    errVec   = '0;
    actVec   = '0;
    errVecW  = '0;
    actVecW  = '0;

    #2;
    checkOutput("reset_result", 64'(resMain), 64'h0);
    checkOutput("reset_valid", 64'(validMain), 64'h0);
    checkOutput("reset_error", 64'(errMain), 64'h0);
    @(negedge clk);
    rst = 1'b1;

    applyStimulus({5{8'd16}}, {5{8'd8}});
    waitValid();
    checkOutput("half_result", 64'(resMain), 64'(EXP_FOURS));
    checkOutput("half_latency", 64'(latMain), 64'd3);
    checkOutput("half_error", 64'(errMain), 64'h0);
    checkOutput("t1_result", 64'(resT1), 64'(EXP_FOURS));
    checkOutput("t1_latency", 64'(latT1), 64'd5);
    checkOutput("t5_result", 64'(resT5), 64'(EXP_FOURS));
    checkOutput("t5_latency", 64'(latT5), 64'd1);

    applyStimulus(E_MIXED, A_MIXED);
    waitValid();
    checkOutput("mixed_result", 64'(resMain), 64'(EXP_MIXED));
    checkOutput("mixed_latency", 64'(latMain), 64'd3);
    checkOutput("mixed_error", 64'(errMain), 64'h0);
    checkOutput("mixed_t1_result", 64'(resT1), 64'(EXP_MIXED));
    checkOutput("mixed_t5_result", 64'(resT5), 64'(EXP_MIXED));

    applyStimulusWide(E_W_OVF, A_W_OVF);
    waitValid();
    checkOutput("wide_ovf_result", 64'(resW), 64'(EXP_W_OVF));
    checkOutput("wide_ovf_error", 64'(errW), 64'h1);
    checkOutput("wide_ovf_latency", 64'(latW), 64'd3);

    applyStimulusWide({5{12'd16}}, {5{8'd8}});
    waitValid();
    checkOutput("wide_clean_result", 64'(resW), 64'(EXP_FOURS));
    checkOutput("wide_clean_error", 64'(errW), 64'h0);

    applyStimulusWide(E_W_OVF, A_W_OVF);
    waitValid();
    checkOutput("wide_ovf2_error", 64'(errW), 64'h1);

    // start held high for ten edges: accepted at E1, E5, E9; valid rises at E4, E8, E12.
    @(negedge clk);
    errVec    = {5{8'd16}};
    actVec    = {5{8'd8}};
    start     = 1'b1;
    prevValid = validMain;
    rises     = 0;
    validAtE5 = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk);
      #1;
      if (e == 10) start = 1'b0;
      if (validMain && !prevValid) rises++;
      if (e == 5) validAtE5 = validMain;
      prevValid = validMain;
    end
    checkOutput("pulse_ops", 64'(rises), 64'd3);
    checkOutput("pulse_valid_drop", 64'(validAtE5), 64'h0);
    checkOutput("pulse_result", 64'(resMain), 64'(EXP_FOURS));

    applyStimulus(E_MIXED, A_MIXED);
    @(posedge clk);
    #1;
    checkOutput("partial_result", 64'(resMain), 64'h00_00_00_00_FA);
    rst = 1'b0;
    #1;
    checkOutput("rst_result", 64'(resMain), 64'h0);
    checkOutput("rst_valid", 64'(validMain), 64'h0);
    checkOutput("rst_error_wide", 64'(errW), 64'h0);
    checkOutput("rst_valid_wide", 64'(validW), 64'h0);
    checkOutput("rst_result_wide", 64'(resW), 64'h0);
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(E_MIXED, A_MIXED);
    waitValid();
    checkOutput("post_rst_result", 64'(resMain), 64'(EXP_MIXED));
    checkOutput("post_rst_latency", 64'(latMain), 64'd3);
    checkOutput("post_rst_error", 64'(errMain), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
